// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared definitions for the 4x4 systolic array sequencer.
// Contents: array dimension, default feed/drain cycle counts, counter and
// index widths, matrix-select constants, and the controller state encoding.
package systolic_seq_ctrl_pkg;

    localparam int N             = 4;
    localparam int IDX_W         = $clog2(N);
    localparam int FEED_CYC_DEF  = 2 * N - 1;
    localparam int DRAIN_CYC_DEF = N - 1;
    localparam int CNT_W         = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Bus between host/load logic, the sequencer and the array edges.
// Host side (master): wr_en, wr_sel, wr_row, wr_col, wr_data, start.
// Sequencer side (slave): wr_err, busy, done, arr_clr, west0..3, north0..3.
interface systolic_seq_ctrl_if
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int DW = 32
);
    logic             wr_en;
    logic             wr_sel;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] wr_col;
    logic [DW-1:0]    wr_data;
    logic             wr_err;
    logic             start;
    logic             busy;
    logic             done;
    logic             arr_clr;
    logic [DW-1:0]    west0, west1, west2, west3;
    logic [DW-1:0]    north0, north1, north2, north3;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  wr_err, busy, done, arr_clr,
        input  west0, west1, west2, west3,
        input  north0, north1, north2, north3
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output wr_err, busy, done, arr_clr,
        output west0, west1, west2, west3,
        output north0, north1, north2, north3
    );

endinterface

// File: rtl/systolic_seq_ctrl_skew_row_mux.sv
// Skew selector for one array edge.
// Picks element (cnt - EDGE) of a buffered row/column when that index lies in
// 0..N-1 and feeding is enabled; otherwise outputs zero padding.
// Ports: en (feeding), cnt (feed cycle), line (N buffered elements), elem.
module skew_row_mux
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int DW   = 32,
    parameter int EDGE = 0
) (
    input  logic                 en,
    input  logic [CNT_W-1:0]     cnt,
    input  logic [N-1:0][DW-1:0] line,
    output logic [DW-1:0]        elem
);

    logic [CNT_W-1:0] k;

    assign k = cnt - CNT_W'(EDGE);

    always_comb begin
        elem = '0;
        if (en && (cnt >= CNT_W'(EDGE)) && (k < CNT_W'(N))) begin
            elem = line[k[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic MAC array.
// Buffers A and B through the write port, then runs CLEAR -> FEED -> DRAIN ->
// DONE, streaming skewed, zero-padded operands onto the array edges.
// Ports: clk, rst_n (async, active low), bus (slave side of
// systolic_seq_ctrl_if: write port, start/busy/done, arr_clr, edge operands).
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int FEED_CYC  = FEED_CYC_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_seq_ctrl_if.slave   bus
);

    state_t                        state, state_next;
    logic [CNT_W-1:0]              cnt, cnt_next;
    logic                          feed_next;
    logic                          wr_err_q;
    logic [N-1:0][N-1:0][DW-1:0]   a_buf, b_buf;
    logic [N-1:0][N-1:0][DW-1:0]   b_col;
    logic [N-1:0][DW-1:0]          west_d, north_d, west_q, north_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (bus.start) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = FEED;
                cnt_next   = '0;
            end
            FEED: begin
                if (cnt == CNT_W'(FEED_CYC - 1)) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Operands are registered, so the muxes look one cycle ahead at the
    // next state/count; the value then sits on the port during that cycle.
    assign feed_next = (state_next == FEED);

    // Writes land only while idle; this includes the cycle an accepted start
    // is sampled, so that write is seen by the job it launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_buf    <= '0;
            b_buf    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en && (state != IDLE);
            if (bus.wr_en && (state == IDLE)) begin
                if (bus.wr_sel == SEL_B) begin
                    b_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end else begin
                    a_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_edge
        for (genvar r = 0; r < N; r++) begin : g_col
            assign b_col[g][r] = b_buf[r][g];
        end

        skew_row_mux #(.DW(DW), .EDGE(g)) u_west (
            .en   (feed_next),
            .cnt  (cnt_next),
            .line (a_buf[g]),
            .elem (west_d[g])
        );

        skew_row_mux #(.DW(DW), .EDGE(g)) u_north (
            .en   (feed_next),
            .cnt  (cnt_next),
            .line (b_col[g]),
            .elem (north_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            west_q  <= '0;
            north_q <= '0;
        end else begin
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.arr_clr = (state == CLEAR);
    assign bus.wr_err  = wr_err_q;

    assign bus.west0  = west_q[0];
    assign bus.west1  = west_q[1];
    assign bus.west2  = west_q[2];
    assign bus.west3  = west_q[3];
    assign bus.north0 = north_q[0];
    assign bus.north1 = north_q[1];
    assign bus.north2 = north_q[2];
    assign bus.north3 = north_q[3];

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl.
// A job-level reference model (cycles since accepted start, buffer contents)
// is compared with the DUT on every falling edge; a systolic array emulation
// driven by the DUT edges produces results checked against A*B.
module tb_systolic_seq_ctrl;
    import systolic_seq_ctrl_pkg::*;

    localparam int          DW      = 32;
    localparam int          JOB_LEN = 12;
    localparam logic [63:0] OVF     = 64'hFFFF_FFF8_0000_0004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.DW(DW)) bus();

    systolic_seq_ctrl #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] west  [4];
    logic [DW-1:0] north [4];
    assign west[0]  = bus.west0;
    assign west[1]  = bus.west1;
    assign west[2]  = bus.west2;
    assign west[3]  = bus.west3;
    assign north[0] = bus.north0;
    assign north[1] = bus.north1;
    assign north[2] = bus.north2;
    assign north[3] = bus.north3;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: m_k counts cycles since the accepted start edge
    // (0 = idle, 1 = clear, 2..8 = feed t=0..6, 9..11 = drain, 12 = done).
    logic [DW-1:0] m_a [4][4];
    logic [DW-1:0] m_b [4][4];
    int            m_k;
    logic          m_wr_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    m_a[i][j] <= '0;
                    m_b[i][j] <= '0;
                end
            m_k      <= 0;
            m_wr_err <= 1'b0;
        end else begin
            m_wr_err <= bus.wr_en && (m_k != 0);
            if (m_k == 0) begin
                if (bus.wr_en) begin
                    if (bus.wr_sel) m_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
                    else            m_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
                end
                if (bus.start) m_k <= 1;
            end else if (m_k == JOB_LEN) begin
                m_k <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [DW-1:0] exp_west(input int i);
        int t = m_k - 2;
        if (m_k >= 2 && t <= 6 && t - i >= 0 && t - i <= 3) return m_a[i][t-i];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_north(input int j);
        int t = m_k - 2;
        if (m_k >= 2 && t <= 6 && t - j >= 0 && t - j <= 3) return m_b[t-j][j];
        return '0;
    endfunction

    function automatic logic [63:0] mm(input int i, input int j);
        logic [63:0] s = '0;
        for (int k = 0; k < 4; k++) s += 64'(m_a[i][k]) * 64'(m_b[k][j]);
        return s;
    endfunction

    always @(negedge clk) begin
        check_output("busy",    64'(bus.busy),    64'(m_k != 0));
        check_output("done",    64'(bus.done),    64'(m_k == JOB_LEN));
        check_output("arr_clr", 64'(bus.arr_clr), 64'(m_k == 1));
        check_output("wr_err",  64'(bus.wr_err),  64'(m_wr_err));
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("west%0d", i),  64'(west[i]),  64'(exp_west(i)));
            check_output($sformatf("north%0d", i), 64'(north[i]), 64'(exp_north(i)));
        end
    end

    // Output-stationary array emulation fed from the DUT edge ports.
    logic [63:0]   acc [4][4];
    logic [DW-1:0] h   [4][4];
    logic [DW-1:0] v   [4][4];

    always @(negedge clk) begin : arr_emu
        logic [DW-1:0] a_in, b_in;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (bus.arr_clr) begin
                    acc[i][j] <= '0;
                    h[i][j]   <= '0;
                    v[i][j]   <= '0;
                end else begin
                    if (j == 0) a_in = west[i];  else a_in = h[i][j-1];
                    if (i == 0) b_in = north[j]; else b_in = v[i-1][j];
                    acc[i][j] <= acc[i][j] + 64'(a_in) * 64'(b_in);
                    h[i][j]   <= a_in;
                    v[i][j]   <= b_in;
                end
            end
    end

    logic [DW-1:0] w0_log [32];
    logic [DW-1:0] w3_log [32];
    logic [DW-1:0] n0_log [32];
    int clr_cnt, done_cnt, done_k, wr_err_cnt;

    // All tasks start and end at posedge + 1.
    task automatic write_elem(input logic sel, input int r, input int c, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 2'(c);
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                write_elem(SEL_A, i, j, (i == j) ? 32'd1 : 32'd0);
                write_elem(SEL_B, i, j, 32'(4 * i + j + 1));
            end
    endtask

    task automatic apply_stimulus(input int inject_k, input int rst_k, input logic pre_write);
        bus.start = 1'b1;
        if (pre_write) begin
            bus.wr_en = 1'b1; bus.wr_sel = SEL_A; bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 32'd7;
        end
        clr_cnt = 0; done_cnt = 0; done_k = -1; wr_err_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            bus.start = (k == inject_k);
            bus.wr_en = (k == inject_k);
            if (k == inject_k) begin
                bus.wr_sel = SEL_A; bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 32'd5;
            end
            if (k == rst_k + 2) rst_n = 1'b1;
            if (k == rst_k) begin
                #2; rst_n = 1'b0; #1;
                check_output("rst_busy", 64'(bus.busy), 64'd0);
                check_output("rst_done", 64'(bus.done), 64'd0);
                check_output("rst_clr",  64'(bus.arr_clr), 64'd0);
                for (int i = 0; i < 4; i++) begin
                    check_output($sformatf("rst_west%0d", i),  64'(west[i]),  64'd0);
                    check_output($sformatf("rst_north%0d", i), 64'(north[i]), 64'd0);
                end
            end
            @(negedge clk);
            w0_log[k] = west[0];
            w3_log[k] = west[3];
            n0_log[k] = north[0];
            if (bus.arr_clr) clr_cnt++;
            if (bus.wr_err)  wr_err_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k > 0) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check_output($sformatf("%s_acc%0d%0d", tag, i, j), acc[i][j], mm(i, j));
    endtask

    task automatic check_all_const(input string tag, input logic [63:0] val);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check_output($sformatf("%s_acc%0d%0d", tag, i, j), acc[i][j], val);
    endtask

    logic [DW-1:0] exp_n0 [7];
    logic [DW-1:0] exp_w3 [7];

    initial begin
        exp_n0 = '{32'd1, 32'd5, 32'd9, 32'd13, 32'd0, 32'd0, 32'd0};
        exp_w3 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0;

        #12;
        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_clr",  64'(bus.arr_clr), 64'd0);
        check_output("reset_west0", 64'(west[0]), 64'd0);
        check_output("reset_north3", 64'(north[3]), 64'd0);
        @(negedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] identity feed");
        load_identity();
        apply_stimulus(-1, -1, 1'b0);
        check_output("t1_done_lat", 64'(done_k), 64'd12);
        check_output("t1_clr_cnt", 64'(clr_cnt), 64'd1);
        for (int t = 0; t < 7; t++) begin
            check_output($sformatf("t1_north0_t%0d", t), 64'(n0_log[t+2]), 64'(exp_n0[t]));
            check_output($sformatf("t1_west3_t%0d", t),  64'(w3_log[t+2]), 64'(exp_w3[t]));
        end
        check_output("t1_result5", acc[1][1], 64'd6);
        check_results("t1");

        $display("[TB] overflow");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                write_elem(SEL_A, i, j, 32'hFFFF_FFFF);
                write_elem(SEL_B, i, j, 32'hFFFF_FFFF);
            end
        apply_stimulus(-1, -1, 1'b0);
        check_output("t2_clr_cnt", 64'(clr_cnt), 64'd1);
        check_all_const("t2", OVF);

        $display("[TB] back-to-back");
        apply_stimulus(-1, -1, 1'b0);
        check_output("t3_clr_cnt", 64'(clr_cnt), 64'd1);
        check_output("t3_done_lat", 64'(done_k), 64'd12);
        check_all_const("t3", OVF);

        $display("[TB] busy rejection");
        apply_stimulus(4, -1, 1'b0);
        check_output("t4_wr_err_cnt", 64'(wr_err_cnt), 64'd1);
        check_output("t4_done_cnt", 64'(done_cnt), 64'd1);
        check_all_const("t4", OVF);
        repeat (3) @(posedge clk);
        #1;
        apply_stimulus(-1, -1, 1'b0);
        check_all_const("t4b", OVF);

        $display("[TB] reset mid-job");
        load_identity();
        apply_stimulus(-1, 6, 1'b0);
        check_output("t5_done_cnt", 64'(done_cnt), 64'd0);
        load_identity();
        apply_stimulus(-1, -1, 1'b0);
        check_output("t5_result5", acc[1][1], 64'd6);
        check_results("t5");

        $display("[TB] same-cycle write and start");
        apply_stimulus(-1, -1, 1'b1);
        check_output("t6_west0_t0", 64'(w0_log[2]), 64'd7);
        check_output("t6_acc00", acc[0][0], 64'd7);
        check_results("t6");

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            bus.wr_en   = ($urandom_range(0, 1) == 1);
            bus.wr_sel  = 1'($urandom_range(0, 1));
            bus.wr_row  = 2'($urandom_range(0, 3));
            bus.wr_col  = 2'($urandom_range(0, 3));
            bus.wr_data = $urandom;
            bus.start   = ($urandom_range(0, 7) == 0);
            @(negedge clk); #1;
            if (bus.done) check_results("rand");
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
